uart_receiver: RTL and testbench
================================

# uart_receiver

Asynchronous serial receiver: the receive side of the team's 8N1 UART link, paired with the existing transmitter at 250000 baud from the 100 MHz system clock. It synchronises the RX pin, detects and validates the start bit, samples eight data bits LSB-first at bit centres, and checks the stop bit. It presents each byte with a one-cycle valid strobe, or flags a framing error. It sits between the board RX pin and the consuming logic (command parser / loopback path).

## Interface

- CLKS_PER_BIT, 400: system clocks per bit (100 MHz / 250000 baud); legal range ≥ 4; HALF = floor(CLKS_PER_BIT/2).
- CLK  in  1  system clock, all state on rising edge.
- RST  in  1  reset; asynchronous, active-high.
- RX  in  1  serial line, idle high, asynchronous to CLK.
- DATA  out  8  last correctly framed byte; held until the next good frame.
- VALID  out  1  one-cycle pulse, DATA updated this cycle.
- FRAME_ERR  out  1  one-cycle pulse, stop bit sampled low.
- BUSY  out  1  high in any state other than IDLE.

## Operation

- RX passes through a 2-flop synchroniser (rx_s), with both flops reset to 1; rx_prev holds the previous rx_s value and also resets to 1.
- Reset values: DATA=0x00, VALID=0, FRAME_ERR=0, BUSY=0, state=IDLE, bit counter=0, clock counter=0.
- IDLE: on a falling edge (rx_prev=1, rx_s=0), go to START and set the clock counter to 0. A line held low never re-triggers.
- START: the counter increments each cycle. When the counter reaches HALF-1, sample rx_s.
  - If rx_s=0: go to DATA, clear the counter and the bit index.
  - If rx_s=1: treat as a glitch and return to IDLE with no output pulse.
- DATA: when the counter reaches CLKS_PER_BIT-1, sample rx_s into shift[bit index] (LSB first), clear the counter, and increment the index. After index 7 is sampled, go to STOP.
- STOP: when the counter reaches CLKS_PER_BIT-1, sample rx_s.
  - If rx_s=1: load DATA from the shift register and pulse VALID.
  - If rx_s=0: pulse FRAME_ERR and leave DATA unchanged.
  - In both cases return to IDLE in the same edge, so a start bit immediately following can be caught.
- VALID and FRAME_ERR are registered and are never high together.
- Counter width is $clog2(CLKS_PER_BIT), unsigned. The counter wraps only via explicit clear and never free-runs.
- Reset mid-frame: all state returns to reset values immediately. The partial byte is discarded and no pulse is issued.
- Break (RX low ≥ 10 bits): exactly one FRAME_ERR pulse, then the block stays in IDLE until RX goes high and then falls again.

## Timing

- Pin-to-detection: 2 cycles of synchroniser latency, plus 1 cycle for edge detection (E0 is the edge that enters START).
- Start sample at E0+HALF. Data bit k (0..7) sampled at E0+HALF+(k+1)·CLKS_PER_BIT. Stop sampled at E0+HALF+9·CLKS_PER_BIT.
- VALID/FRAME_ERR are high during the cycle after the stop-sample edge. With the default parameter: 3 + 200 + 3600 = 3803 cycles after the first CLK edge at which the pin is low.
- BUSY rises the cycle after E0 and falls with the VALID/FRAME_ERR pulse.
- Tolerates ±4% baud mismatch (centre sampling, 10 bit periods).
- No backpressure: the consumer must take DATA within one frame time (4000 cycles) or accept overwrite.

## Structure

- Shared package uart_pkg holds:
  - state encoding (IDLE, START, DATA, STOP; 2 bits);
  - DATA_BITS=8;
  - default CLKS_PER_BIT=400, shared with the transmitter so both ends agree.
- One sub-module, uart_rx_sync: 2-flop synchroniser with asynchronous reset-to-1, reusable for other pin inputs.
- Elaboration check: CLKS_PER_BIT ≥ 4.

## Test plan

- Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) at 400 clocks/bit → DATA=0xA5, VALID a single pulse exactly 3803 cycles after the RX fall, FRAME_ERR=0.
- RX low pulse of 50 cycles, then high → no VALID, no FRAME_ERR, BUSY returns to 0 at cycle E0+200.
- Frame 0x3C with stop bit 0 after a prior good 0x11 → FRAME_ERR one pulse, DATA stays 0x11, VALID stays 0.
- Back-to-back frames 0x00 then 0xFF, with the second start bit directly after the first stop bit → two VALID pulses 4000 cycles apart, DATA=0x00 then 0xFF.
- RST asserted at cycle 1500 of a frame, released 10 cycles later, followed by frame 0x5A → outputs at reset values during reset, no pulse from the aborted frame, then DATA=0x5A with VALID.
- RX held low for 20 bit times, then high, then frame 0x81 → exactly one FRAME_ERR, then DATA=0x81 with VALID; frames at ±3% bit period also decode correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by both ends of the 8N1 UART link.
//   uart_state_e      - receiver FSM encoding (2 bits)
//   DATA_BITS         - payload bits per frame
//   UART_CLKS_PER_BIT - default bit period in system clocks (100 MHz / 250000 baud);
//                       the transmitter uses the same value so both ends agree on it.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS         = 8;
  localparam int UART_CLKS_PER_BIT = 400;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for an asynchronous pin input.
// Both flops reset to 1, which is the idle level of a UART line.
//   clk - destination clock
//   rst - asynchronous, active-high reset
//   d   - asynchronous input pin
//   q   - synchronised output, two clocks of latency
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 asynchronous serial receiver.
// Synchronises RX, qualifies the start bit at its centre, samples eight data
// bits LSB first at bit centres and checks the stop bit.
//   CLK       - system clock
//   RST       - asynchronous, active-high reset
//   RX        - serial line, idle high
//   DATA      - last correctly framed byte, held until the next good frame
//   VALID     - one-cycle pulse, DATA updated this cycle
//   FRAME_ERR - one-cycle pulse, stop bit sampled low (DATA untouched)
//   BUSY      - receiver is inside a frame
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] DATA,
  output logic                 VALID,
  output logic                 FRAME_ERR,
  output logic                 BUSY
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int IW   = $clog2(DATA_BITS);

  if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
    $error("uart_receiver: CLKS_PER_BIT must be >= 4");
  end

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 rx_prev_q;
  logic                 rx_s;

  uart_rx_sync u_sync (
    .clk (CLK),
    .rst (RST),
    .d   (RX),
    .q   (rx_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Edge, not level: a line stuck low (break) cannot re-trigger.
        if (rx_prev_q && !rx_s) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end else begin
            state_d = ST_IDLE;  // glitch shorter than half a bit
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          shift_d[idx_q] = rx_s;
          cnt_d          = '0;
          idx_d          = idx_q + 1'b1;
          if (idx_q == IW'(DATA_BITS - 1)) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          // Back to IDLE half a bit early so a start bit right after
          // the stop bit is still seen as a falling edge.
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      rx_prev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      rx_prev_q <= rx_s;
    end
  end

  assign DATA      = data_q;
  assign VALID     = valid_q;
  assign FRAME_ERR = ferr_q;
  assign BUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: self-checking bench for uart_receiver.
// A monitor logs every VALID/FRAME_ERR pulse with its cycle number; each test
// builds the expected pulse list from a frame-level model (one outcome per
// frame at a fixed offset from the line's falling edge) and compares.
module tb_uart_receiver;

  localparam int CPB = 400;
  // Falling edge driven just after edge t: pulse observed after edge t + LAT.
  localparam int LAT = 3 + CPB / 2 + 9 * CPB;

  typedef struct packed {
    logic [31:0] cyc;
    logic        v;
    logic        fe;
    logic [7:0]  d;
    logic        bsy;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ferr;
  logic       busy;

  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] model_data;
  ev_t        ev_q[$];
  ev_t        exp_q[$];

  always #5 clk = ~clk;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .CLK       (clk),
    .RST       (rst),
    .RX        (rx),
    .DATA      (data),
    .VALID     (valid),
    .FRAME_ERR (ferr),
    .BUSY      (busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (valid || ferr) ev_q.push_back(ev_t'{32'(cyc), valid, ferr, data, busy});

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Drives one frame (or its first 'limit' cycles), then leaves the line high.
  task automatic drive_frame(input logic [7:0] b, input logic stop, input int period,
                             input int limit, output int t0);
    t0 = cyc;
    for (int i = 0; i < 10 * period && i < limit; i++) begin
      int k;
      k = i / period;
      rx = (k == 0) ? 1'b0 : (k == 9) ? stop : b[k-1];
      @(posedge clk); #1;
    end
    rx = 1'b1;
  endtask

  function automatic ev_t model_frame(input int t, input logic [7:0] b, input logic stop);
    ev_t e;
    if (stop) model_data = b;
    e.cyc = 32'(t + LAT);
    e.v   = stop;
    e.fe  = !stop;
    e.d   = model_data;
    e.bsy = 1'b0;
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b0; rx = 1'b1;
    #2 rst = 1'b1;
    model_data = 8'h00;
    idle(3);
    vectors++;
    if ({data, valid, ferr, busy} !== 11'h000) begin
      miscompares++;
      $display("FAIL reset_outputs: got data=%h v=%b fe=%b busy=%b, want 00 0 0 0", data, valid, ferr, busy);
    end
    rst = 1'b0;
    idle(20);
    vectors++;
    if ({data, valid, ferr, busy} !== 11'h000) begin
      miscompares++;
      $display("FAIL post_reset_idle: got data=%h v=%b fe=%b busy=%b, want 00 0 0 0", data, valid, ferr, busy);
    end
  endtask

  task automatic test_frame_a5();
    int t;
    ev_q.delete(); exp_q.delete();
    drive_frame(8'hA5, 1'b1, CPB, 1 << 30, t);
    exp_q.push_back(model_frame(t, 8'hA5, 1'b1));
    idle(200);
    vectors++;
    if (ev_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL a5_count: got %0d pulses, want %0d", ev_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= ev_q.size() || ev_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL a5_pulse%0d: got %p, want %p", i, ev_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (data !== 8'hA5) begin
      miscompares++;
      $display("FAIL a5_hold: got data=%h, want a5", data);
    end
  endtask

  task automatic test_glitch();
    int t0;
    ev_q.delete();
    t0 = cyc;
    for (int i = 0; i < 300; i++) begin
      rx = (i < 50) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      if (cyc == t0 + 2 || cyc == t0 + 3 || cyc == t0 + 202 || cyc == t0 + 203) begin
        vectors++;
        if (busy !== (cyc == t0 + 3 || cyc == t0 + 202)) begin
          miscompares++;
          $display("FAIL glitch_busy@+%0d: got %b, want %b", cyc - t0, busy,
                   (cyc == t0 + 3 || cyc == t0 + 202));
        end
      end
    end
    vectors++;
    if (ev_q.size() != 0) begin
      miscompares++;
      $display("FAIL glitch_pulses: got %0d pulses, want 0", ev_q.size());
    end
  endtask

  task automatic test_frame_err();
    int t1, t2;
    ev_q.delete(); exp_q.delete();
    drive_frame(8'h11, 1'b1, CPB, 1 << 30, t1);
    exp_q.push_back(model_frame(t1, 8'h11, 1'b1));
    idle(20);
    drive_frame(8'h3C, 1'b0, CPB, 1 << 30, t2);
    exp_q.push_back(model_frame(t2, 8'h3C, 1'b0));
    idle(200);
    vectors++;
    if (ev_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL ferr_count: got %0d pulses, want %0d", ev_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= ev_q.size() || ev_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL ferr_pulse%0d: got %p, want %p", i, ev_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (data !== 8'h11) begin
      miscompares++;
      $display("FAIL ferr_hold: got data=%h, want 11", data);
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    ev_q.delete(); exp_q.delete();
    drive_frame(8'h00, 1'b1, CPB, 1 << 30, t1);
    drive_frame(8'hFF, 1'b1, CPB, 1 << 30, t2);
    exp_q.push_back(model_frame(t1, 8'h00, 1'b1));
    exp_q.push_back(model_frame(t2, 8'hFF, 1'b1));
    idle(200);
    vectors++;
    if (ev_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d pulses, want %0d", ev_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= ev_q.size() || ev_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL b2b_pulse%0d: got %p, want %p", i, ev_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int t;
    ev_q.delete(); exp_q.delete();
    drive_frame(8'($urandom), 1'b1, CPB, 1500, t);
    rst = 1'b1;
    model_data = 8'h00;
    idle(5);
    vectors++;
    if ({data, valid, ferr, busy} !== 11'h000) begin
      miscompares++;
      $display("FAIL midrst_outputs: got data=%h v=%b fe=%b busy=%b, want 00 0 0 0", data, valid, ferr, busy);
    end
    idle(5);
    rst = 1'b0;
    idle(50);
    drive_frame(8'h5A, 1'b1, CPB, 1 << 30, t);
    exp_q.push_back(model_frame(t, 8'h5A, 1'b1));
    idle(200);
    vectors++;
    if (ev_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL midrst_count: got %0d pulses, want %0d", ev_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= ev_q.size() || ev_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL midrst_pulse%0d: got %p, want %p", i, ev_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_break();
    int t;
    ev_q.delete(); exp_q.delete();
    t = cyc;
    rx = 1'b0;
    idle(20 * CPB);
    exp_q.push_back(model_frame(t, 8'h00, 1'b0));  // a break reads as 0x00 with a bad stop
    rx = 1'b1;
    idle(CPB);
    drive_frame(8'h81, 1'b1, CPB, 1 << 30, t);
    exp_q.push_back(model_frame(t, 8'h81, 1'b1));
    idle(200);
    vectors++;
    if (ev_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL break_count: got %0d pulses, want %0d", ev_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= ev_q.size() || ev_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL break_pulse%0d: got %p, want %p", i, ev_q[i], exp_q[i]);
      end
    end
  endtask

  // Random bytes, occasional bad stop bits, bit periods within +-3%, random gaps.
  task automatic test_random_skew();
    int t;
    ev_q.delete(); exp_q.delete();
    for (int n = 0; n < 6; n++) begin
      logic [7:0] b;
      logic       stop;
      int         period;
      b      = 8'($urandom);
      stop   = (n < 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
      period = (n == 0) ? 388 : (n == 1) ? 412 : int'($urandom_range(388, 412));
      drive_frame(b, stop, period, 1 << 30, t);
      exp_q.push_back(model_frame(t, b, stop));
      idle(stop ? int'($urandom_range(0, 30)) : int'($urandom_range(10, 30)));
    end
    idle(400);
    vectors++;
    if (ev_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL rand_count: got %0d pulses, want %0d", ev_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= ev_q.size() || ev_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL rand_pulse%0d: got %p, want %p", i, ev_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
    test_break();
    test_random_skew();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
